// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// The line is double-flopped and each bit is sampled at mid-bit by a baud counter.
module uart_rx #(
    parameter int CLOCK_FREQ = 27000000,
    parameter int BAUD_RATE  = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIVIDER = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF    = DIVIDER / 2;
    localparam int CW      = $clog2(DIVIDER);
    localparam logic [CW-1:0] LastCnt = CW'(DIVIDER - 1);
    localparam logic [CW-1:0] HalfCnt = CW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, rxS_q, rxPrev_q;
    logic [CW-1:0]   baudCnt_q, baudCnt_d;
    logic [2:0]      bitIdx_q, bitIdx_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [7:0]      dataOut_q, dataOut_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;

    // Synchroniser and edge history idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b1;
            rxS_q    <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            sync1_q  <= rx;
            rxS_q    <= sync1_q;
            rxPrev_q <= rxS_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            dataOut_q <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            dataOut_q <= dataOut_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        dataOut_d = dataOut_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        unique case (state_q)
            IDLE: begin
                if (rxPrev_q && !rxS_q) state_d = START;
            end
            START: begin
                if (baudCnt_q == HalfCnt) begin
                    bitIdx_d = '0;
                    state_d  = rxS_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baudCnt_q == LastCnt) begin
                    shift_d  = {rxS_q, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (baudCnt_q == LastCnt) begin
                    parity_d = rxS_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (baudCnt_q == LastCnt) begin
                    dataOut_d = shift_q;
                    perr_d    = parity_q != (^shift_q);
                    ferr_d    = ~rxS_q;
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The counter also wraps at the bit boundary so DATA can sample eight times in one state.
    always_comb begin
        baudCnt_d = baudCnt_q + 1'b1;
        if (state_q == IDLE || state_d != state_q || baudCnt_q == LastCnt) baudCnt_d = '0;
    end

    assign data_out   = dataOut_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);

endmodule
